// File: rtl/dot_accum_pkg.sv
// Shared types for the dot-product accumulator: accumulator word, FIFO entry
// and the saturation bounds used when SATURATE_EN is defined.
package dot_accum_pkg;

  localparam int ACC_W = 32;

  typedef logic signed [ACC_W-1:0] acc_t;

  typedef struct packed {
    acc_t data;
    logic last;
  } fifo_entry_t;

  localparam acc_t SAT_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam acc_t SAT_MIN = {1'b1, {(ACC_W-1){1'b0}}};

endpackage

// File: rtl/dot_accumulator_if.sv
// Partial-sum input stream and completed-element valid/ready output stream.
interface dot_accumulator_if #(
  parameter int IWIDTH = 32,
  parameter int OWIDTH = 32
);

  logic signed [IWIDTH-1:0] in_data;
  logic                     in_valid;
  logic signed [OWIDTH-1:0] out_data;
  logic                     out_valid;
  logic                     out_ready;
  logic                     out_last;

  modport master (
    output in_data, in_valid, out_ready,
    input  out_data, out_valid, out_last
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output out_data, out_valid, out_last
  );

endinterface

// File: rtl/acc_fifo.sv
// Show-ahead FIFO of completed elements; a pop frees the slot for a push
// arriving in the same cycle even when full.
module acc_fifo
  import dot_accum_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  fifo_entry_t push_data,
  input  logic        pop,
  output fifo_entry_t head,
  output logic        full,
  output logic        empty
);

  localparam int AW = $clog2(DEPTH);

  fifo_entry_t    mem [DEPTH];
  logic [AW:0]    wr_ptr, rd_ptr;
  logic           do_push, do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: storage has no reset; the empty gate on head keeps stale entries invisible.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/dot_accumulator.sv
// Accumulates num_chunks signed partials per output element and buffers the
// results; define SATURATE_EN for clamped instead of wrapping accumulation.
module dot_accumulator
  import dot_accum_pkg::*;
#(
  parameter int IWIDTH     = 32,
  parameter int OWIDTH     = ACC_W,  // must equal ACC_W in dot_accum_pkg
  parameter int MAX_CHUNKS = 64,
  parameter int MAX_ROWS   = 1024,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [$clog2(MAX_CHUNKS+1)-1:0] num_chunks,
  input  logic [$clog2(MAX_ROWS+1)-1:0]   num_rows,
  dot_accumulator_if.slave                bus,
  output logic                            busy,
  output logic                            overflow
);

  localparam int CW = $clog2(MAX_CHUNKS+1);
  localparam int RW = $clog2(MAX_ROWS+1);

  logic [CW-1:0]            chunk_cnt, lat_chunks, eff_chunks;
  logic [RW-1:0]            row_cnt, lat_rows, eff_rows;
  logic signed [IWIDTH-1:0] in_raw;
  logic signed [OWIDTH-1:0] in_ext;
  acc_t                     acc, base, sum;
  logic                     elem_done, elem_last;
  logic                     pend_valid, fifo_full, fifo_empty, pop;
  fifo_entry_t              pend, head;

  // Sizes are sampled from the ports only on the first partial of an element.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    eff_chunks = lat_chunks;
    eff_rows   = lat_rows;
    if (chunk_cnt == '0) begin
      eff_chunks = (num_chunks == '0) ? CW'(1) : num_chunks;
      eff_rows   = (num_rows == '0)   ? RW'(1) : num_rows;
    end
  end

  assign in_raw = bus.in_data;
  assign in_ext = OWIDTH'(in_raw);
  assign base   = (chunk_cnt == '0) ? '0 : acc;

`ifdef SATURATE_EN
  logic signed [OWIDTH:0] wide;

  always_comb begin
    wide = {base[OWIDTH-1], base} + {in_ext[OWIDTH-1], in_ext};
    sum  = wide[OWIDTH-1:0];
    if (wide[OWIDTH] != wide[OWIDTH-1]) sum = wide[OWIDTH] ? SAT_MIN : SAT_MAX;
  end
`else
  assign sum = base + in_ext;
`endif

  assign elem_done = bus.in_valid && (chunk_cnt == eff_chunks - CW'(1));
  assign elem_last = (row_cnt == eff_rows - RW'(1));
  assign busy      = (chunk_cnt != '0);

  // NOTE: sequential state uses <= so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      chunk_cnt  <= '0;
      row_cnt    <= '0;
      lat_chunks <= '0;
      lat_rows   <= '0;
      acc        <= '0;
      pend       <= '0;
      pend_valid <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      pend_valid <= elem_done;
      if (bus.in_valid) begin
        pend <= '{data: sum, last: elem_last};
        if (chunk_cnt == '0) begin
          lat_chunks <= eff_chunks;
          lat_rows   <= eff_rows;
        end
        if (elem_done) begin
          chunk_cnt <= '0;
          row_cnt   <= elem_last ? '0 : row_cnt + RW'(1);
        end else begin
          acc       <= sum;
          chunk_cnt <= chunk_cnt + CW'(1);
        end
      end
      // Counters above advance regardless, so a dropped element keeps alignment.
      if (pend_valid && fifo_full && !pop) overflow <= 1'b1;
    end
  end

  assign pop = bus.out_valid && bus.out_ready;

  acc_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (pend_valid),
    .push_data (pend),
    .pop       (pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign bus.out_valid = !fifo_empty;
  assign bus.out_data  = head.data;
  assign bus.out_last  = head.last;

endmodule
